// File: rtl/div_sequencer.sv
// Multi-cycle restoring radix-2 divider for MIPS DIV/DIVU in the execute stage.
// Computes one quotient bit per cycle and stalls the pipeline until results are ready.
module div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stallE,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             bz_q, bz_d;
    logic             dbz_q, dbz_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] fin_quo, fin_rem;

    // Operand magnitudes; only signed ops strip the sign.
    always_comb begin
        sign_a = signedE & a[WIDTH-1];
        sign_b = signedE & b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    // One restoring step: the borrow bit of the widened subtract decides the quotient bit.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            step_rem = trial[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = rem_sh[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b0};
        end
        // A zero divisor leaves |a| in the remainder, so the dividend-sign fix-up restores a.
        fin_quo = bz_q ? '1 : (neg_quo_q ? -step_quo : step_quo);
        fin_rem = neg_rem_q ? -step_rem : step_rem;
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        count_d     = count_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        bz_d        = bz_q;
        dbz_d       = dbz_q;
        stallE      = 1'b0;
        ready       = 1'b0;

        case (state_q)
            IDLE: begin
                if (startE && !annul) begin
                    stallE    = 1'b1;
                    rem_d     = '0;
                    quo_d     = mag_a;
                    dvs_d     = mag_b;
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    bz_d      = (b == '0);
                    dbz_d     = 1'b0;
                    count_d   = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                stallE = 1'b1;
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        quotient_d  = fin_quo;
                        remainder_d = fin_rem;
                        dbz_d       = bz_q;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                ready   = !annul;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            count_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            bz_q        <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            count_q     <= count_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            bz_q        <= bz_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
